// File: rtl/cr_huf_comp_st_lut_wr.sv
// cr_huf_comp_st_lut_wr
//   Builds the small-table (ST) Huffman LUT from per-symbol code lengths
//   delivered by the tree walker. The block collects the lengths and
//   histograms them. It derives the first canonical code of every length and
//   checks the Kraft sum. It then writes every LUT entry with its canonical
//   MSB-first code, right-justified. Finally it pulses st_st_lut_wr_done to
//   the ST state machine.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   tw_st_len_valid       code length beat valid (held until st_len_rdy)
//   tw_st_len_sym         symbol index of the beat
//   tw_st_len             code length of the beat (0 = unused symbol)
//   tw_st_len_last        final beat of the table
//   st_len_rdy            beat accepted when valid & rdy
//   lut_wr_en             LUT write strobe, one entry per cycle
//   lut_wr_addr           LUT address (symbol)
//   lut_wr_code           canonical code, right-justified
//   lut_wr_len            code length written
//   st_st_lut_wr_done     1-cycle pulse after all NUM_SYM entries are written
//   st_lut_oversub        1-cycle pulse with done: Kraft sum oversubscribed
//   st_lut_len_err        1-cycle pulse: previous beat dropped (out of range)
module cr_huf_comp_st_lut_wr #(
  parameter int NUM_SYM = 286,
  parameter int SYM_W   = 9,
  parameter int MAX_LEN = 15,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tw_st_len_valid,
  input  logic [SYM_W-1:0]   tw_st_len_sym,
  input  logic [LEN_W-1:0]   tw_st_len,
  input  logic               tw_st_len_last,
  output logic               st_len_rdy,
  output logic               lut_wr_en,
  output logic [SYM_W-1:0]   lut_wr_addr,
  output logic [MAX_LEN-1:0] lut_wr_code,
  output logic [LEN_W-1:0]   lut_wr_len,
  output logic               st_st_lut_wr_done,
  output logic               st_lut_oversub,
  output logic               st_lut_len_err
);

  localparam int IDX_W  = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
  localparam int LIDX_W = $clog2(MAX_LEN + 1);
  localparam int CODE_W = MAX_LEN + 1;
  localparam int KW     = MAX_LEN + 2;
  localparam int BC_W   = SYM_W + 1;
  localparam int CNT_W  = ((IDX_W > LIDX_W) ? IDX_W : LIDX_W) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, NXTC, ASGN, DONE} state_t;

  state_t                        state;
  logic [NUM_SYM-1:0][LEN_W-1:0] len_q;
  logic [MAX_LEN:0][BC_W-1:0]    bl_count;
  logic [MAX_LEN:0][CODE_W-1:0]  next_code;
  logic [CODE_W-1:0]             code_q;
  logic signed [KW-1:0]          left_q;
  logic                          oversub_q;
  // NXTC: current bit length b. ASGN: index of the next entry to prepare.
  logic [CNT_W-1:0]              cnt;

  logic                 beat_acc;
  logic                 beat_ok;
  logic [IDX_W-1:0]     beat_idx;
  logic [LIDX_W-1:0]    beat_lidx;
  logic [LIDX_W-1:0]    b_idx;
  logic [LIDX_W-1:0]    b_prev;
  logic [CODE_W-1:0]    code_nxt;
  logic signed [KW-1:0] left_nxt;
  logic                 nxtc_last;
  logic                 asgn_last;
  logic                 ent_load;
  logic [IDX_W-1:0]     ent_idx;
  logic [LEN_W-1:0]     ent_len;
  logic [LIDX_W-1:0]    ent_lidx;
  logic [CODE_W-1:0]    ent_code;

  // Kraft step: left = 2*left - count, in signed arithmetic.
  function automatic logic signed [KW-1:0] kraft_step(
    input logic signed [KW-1:0] left,
    input logic [BC_W-1:0]      count
  );
    kraft_step = (left <<< 1) - $signed(KW'(count));
  endfunction

  always_comb begin
    beat_acc  = tw_st_len_valid & st_len_rdy;
    beat_ok   = (int'(tw_st_len_sym) < NUM_SYM) && (int'(tw_st_len) <= MAX_LEN);
    beat_idx  = IDX_W'(tw_st_len_sym);
    beat_lidx = LIDX_W'(tw_st_len);
    b_idx     = LIDX_W'(cnt);
    b_prev    = LIDX_W'(cnt - 1'b1);
    // bl_count[0] is never incremented, so b = 1 adds zero.
    code_nxt  = (code_q + CODE_W'(bl_count[b_prev])) << 1;
    left_nxt  = kraft_step(left_q, bl_count[b_idx]);
    nxtc_last = (state == NXTC) && (cnt == CNT_W'(MAX_LEN));
    asgn_last = (state == ASGN) && (cnt == CNT_W'(NUM_SYM));
    // Each LUT entry is prepared one cycle ahead so the write outputs are
    // registered; entry 0 is prepared in the final NXTC cycle.
    ent_load  = nxtc_last || ((state == ASGN) && !asgn_last);
    ent_idx   = (state == ASGN) ? IDX_W'(cnt) : '0;
    ent_len   = len_q[ent_idx];
    ent_lidx  = LIDX_W'(ent_len);
    // next_code[MAX_LEN] is still being written when entry 0 is prepared,
    // so that one case takes the value straight from the code adder.
    ent_code  = (nxtc_last && (ent_lidx == b_idx)) ? code_nxt : next_code[ent_lidx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      st_len_rdy        <= 1'b1;
      lut_wr_en         <= 1'b0;
      lut_wr_addr       <= '0;
      lut_wr_code       <= '0;
      lut_wr_len        <= '0;
      st_st_lut_wr_done <= 1'b0;
      st_lut_oversub    <= 1'b0;
      st_lut_len_err    <= 1'b0;
      len_q             <= '0;
      bl_count          <= '0;
      next_code         <= '0;
      code_q            <= '0;
      left_q            <= '0;
      oversub_q         <= 1'b0;
      cnt               <= '0;
    end else begin
      st_lut_len_err <= beat_acc && !beat_ok;

      case (state)
        IDLE, LOAD: begin
          if (beat_acc) begin
            // A new table starts: forget the previous lengths and histogram.
            if (state == IDLE) begin
              len_q    <= '0;
              bl_count <= '0;
            end
            if (beat_ok) begin
              len_q[beat_idx] <= tw_st_len;
              if (tw_st_len != '0)
                bl_count[beat_lidx] <= (state == IDLE) ? BC_W'(1)
                                                       : bl_count[beat_lidx] + 1'b1;
            end
            if (tw_st_len_last) begin
              state      <= NXTC;
              st_len_rdy <= 1'b0;
              cnt        <= CNT_W'(1);
              code_q     <= '0;
              left_q     <= KW'(1);
              oversub_q  <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end

        NXTC: begin
          next_code[b_idx] <= code_nxt;
          code_q           <= code_nxt;
          // Once oversubscribed the accumulator is frozen.
          if (!oversub_q) begin
            left_q <= left_nxt;
            if (left_nxt < 0)
              oversub_q <= 1'b1;
          end
          if (nxtc_last) begin
            state <= ASGN;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ASGN: begin
          if (asgn_last) begin
            lut_wr_en         <= 1'b0;
            lut_wr_addr       <= '0;
            lut_wr_code       <= '0;
            lut_wr_len        <= '0;
            st_st_lut_wr_done <= 1'b1;
            st_lut_oversub    <= oversub_q;
            state             <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          st_st_lut_wr_done <= 1'b0;
          st_lut_oversub    <= 1'b0;
          oversub_q         <= 1'b0;
          st_len_rdy        <= 1'b1;
          state             <= IDLE;
        end

        default: begin
          state      <= IDLE;
          st_len_rdy <= 1'b1;
        end
      endcase

      // Placed after the case so the post-increment wins over the NXTC
      // write when entry 0 uses length MAX_LEN.
      if (ent_load) begin
        lut_wr_en   <= 1'b1;
        lut_wr_addr <= SYM_W'(ent_idx);
        lut_wr_len  <= ent_len;
        if (ent_len != '0) begin
          lut_wr_code         <= ent_code[MAX_LEN-1:0];
          next_code[ent_lidx] <= ent_code + 1'b1;
        end else begin
          lut_wr_code <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cr_huf_comp_st_lut_wr.sv
// tb_cr_huf_comp_st_lut_wr
//   Directed testbench for cr_huf_comp_st_lut_wr with an 8-entry table.
//   A negedge monitor captures every LUT write and the done, oversub and
//   len_err pulses. Each directed table is compared against hand-computed
//   canonical codes, lengths and cycle timing.
module tb_cr_huf_comp_st_lut_wr;

  localparam int NSYM = 8;
  localparam int SW   = 9;
  localparam int ML   = 15;
  localparam int LW   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic [SW-1:0] sym_i;
  logic [LW-1:0] len_i;
  logic          last_i;
  logic          rdy;
  logic          wr_en;
  logic [SW-1:0] wr_addr;
  logic [ML-1:0] wr_code;
  logic [LW-1:0] wr_len;
  logic          done;
  logic          ovs;
  logic          len_err;

  always #5 clk = ~clk;

  cr_huf_comp_st_lut_wr #(
    .NUM_SYM (NSYM),
    .SYM_W   (SW),
    .MAX_LEN (ML),
    .LEN_W   (LW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .tw_st_len_valid   (valid),
    .tw_st_len_sym     (sym_i),
    .tw_st_len         (len_i),
    .tw_st_len_last    (last_i),
    .st_len_rdy        (rdy),
    .lut_wr_en         (wr_en),
    .lut_wr_addr       (wr_addr),
    .lut_wr_code       (wr_code),
    .lut_wr_len        (wr_len),
    .st_st_lut_wr_done (done),
    .st_lut_oversub    (ovs),
    .st_lut_len_err    (len_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  int wr_cnt, done_cnt, ord_err, err_cnt, ovs_stray;
  int done_cyc, err_cyc, first_wr, last_wr;
  int ovs_at_done, rdy_at_done, rdy_after;
  int mon_addr;
  int m_code   [NSYM];
  int m_len    [NSYM];
  int exp_code [NSYM];
  int exp_len  [NSYM];
  int t1_len   [NSYM] = '{3, 3, 3, 3, 3, 2, 4, 4};
  int t1_code  [NSYM] = '{2, 3, 4, 5, 6, 0, 14, 15};

  always @(negedge clk) begin
    if (wr_en) begin
      mon_addr = int'(wr_addr);
      if (wr_cnt % NSYM == 0 && wr_cnt == 0) first_wr = cyc;
      last_wr = cyc;
      if (mon_addr != wr_cnt % NSYM) ord_err++;
      if (mon_addr < NSYM) begin
        m_code[mon_addr] = int'(wr_code);
        m_len[mon_addr]  = int'(wr_len);
      end
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc    = cyc;
      ovs_at_done = int'(ovs);
      rdy_at_done = int'(rdy);
    end
    if (ovs && !done) ovs_stray++;
    if (len_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (cyc == done_cyc + 1) rdy_after = int'(rdy);
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic clear_mon();
    #1;
    wr_cnt    = 0;
    done_cnt  = 0;
    ord_err   = 0;
    err_cnt   = 0;
    ovs_stray = 0;
    done_cyc  = -10;
    err_cyc   = -10;
    first_wr  = -1;
    last_wr   = -1;
    ovs_at_done = -1;
    rdy_at_done = -1;
    rdy_after   = -1;
    for (int i = 0; i < NSYM; i++) begin
      m_code[i] = -1;
      m_len[i]  = 99;
    end
  endtask

  // Present one beat and hold it until accepted; t_acc is the cycle whose
  // closing edge accepted it.
  task automatic send_beat(input int sym, input int len, input bit last, output int t_acc);
    int waited;
    waited = 0;
    @(negedge clk);
    valid  = 1'b1;
    sym_i  = sym[SW-1:0];
    len_i  = len[LW-1:0];
    last_i = last;
    while (!rdy && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy) begin
      chk_eq("rdy_timeout", rdy, 1);
      t_acc = -1;
    end else begin
      t_acc = cyc;
      @(negedge clk);
    end
    valid  = 1'b0;
    last_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int n;
    n = 0;
    while (done_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk_eq("done_seen", done_cnt, target);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_tbl(input string tag, input int exp_wr, input int exp_ovs);
    for (int i = 0; i < NSYM; i++) begin
      chk_eq($sformatf("%s_len%0d", tag, i), m_len[i], exp_len[i]);
      chk_eq($sformatf("%s_code%0d", tag, i), m_code[i], exp_code[i]);
    end
    chk_eq({tag, "_wr_cnt"}, wr_cnt, exp_wr);
    chk_eq({tag, "_order"}, ord_err, 0);
    chk_eq({tag, "_oversub"}, ovs_at_done, exp_ovs);
    chk_eq({tag, "_ovs_stray"}, ovs_stray, 0);
  endtask

  task automatic send_t1(output int t_last);
    int t;
    t_last = -1;
    for (int i = 0; i < NSYM; i++) begin
      send_beat(i, t1_len[i], i == NSYM - 1, t);
      t_last = t;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, t2;
    rst_n  = 1'b0;
    valid  = 1'b0;
    sym_i  = '0;
    len_i  = '0;
    last_i = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);

    // Reset state
    chk_eq("rst_rdy", rdy, 1);
    chk_eq("rst_wr_en", wr_en, 0);
    chk_eq("rst_addr", wr_addr, 0);
    chk_eq("rst_code", wr_code, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_oversub", ovs, 0);
    chk_eq("rst_len_err", len_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("idle_rdy", rdy, 1);

    // Test 1: canonical codes and latency
    clear_mon();
    send_t1(t);
    wait_done(1, 100);
    exp_len  = t1_len;
    exp_code = t1_code;
    check_tbl("t1", NSYM, 0);
    chk_eq("t1_first_wr", first_wr, t + 16);
    chk_eq("t1_last_wr", last_wr, t + 23);
    chk_eq("t1_done_cyc", done_cyc, t + 24);
    chk_eq("t1_rdy_at_done", rdy_at_done, 0);
    chk_eq("t1_rdy_after", rdy_after, 1);
    chk_eq("t1_len_err", err_cnt, 0);

    // Test 2: single length-1 symbol, incomplete code not flagged
    clear_mon();
    send_beat(5, 1, 1'b1, t);
    wait_done(1, 100);
    exp_len  = '{0, 0, 0, 0, 0, 1, 0, 0};
    exp_code = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_tbl("t2", NSYM, 0);
    chk_eq("t2_done_cyc", done_cyc, t + 24);

    // Test 3: three length-1 codes oversubscribe
    clear_mon();
    send_beat(0, 1, 1'b0, t);
    send_beat(1, 1, 1'b0, t);
    send_beat(2, 1, 1'b1, t);
    wait_done(1, 100);
    exp_len  = '{1, 1, 1, 0, 0, 0, 0, 0};
    exp_code = '{0, 1, 2, 0, 0, 0, 0, 0};
    check_tbl("t3", NSYM, 1);

    // Test 4: table B clears stale entries of table A
    clear_mon();
    send_t1(t);
    wait_done(1, 100);
    clear_mon();
    send_beat(0, 1, 1'b1, t);
    wait_done(1, 100);
    exp_len  = '{1, 0, 0, 0, 0, 0, 0, 0};
    exp_code = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_tbl("t4", NSYM, 0);

    // Maximum length codes, including entry 0 at length MAX_LEN
    clear_mon();
    send_beat(0, 15, 1'b0, t);
    send_beat(1, 15, 1'b0, t);
    send_beat(2, 1, 1'b1, t);
    wait_done(1, 100);
    exp_len  = '{15, 15, 1, 0, 0, 0, 0, 0};
    exp_code = '{16384, 16385, 0, 0, 0, 0, 0, 0};
    check_tbl("tmax", NSYM, 0);

    // Test 5: reset during ASGN
    clear_mon();
    send_t1(t);
    while (cyc < t + 18) @(negedge clk);
    chk_eq("t5_wr_before_rst", wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk_eq("t5_rst_rdy", rdy, 1);
    chk_eq("t5_rst_wr_en", wr_en, 0);
    clear_mon();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk_eq("t5_no_done", done_cnt, 0);
    chk_eq("t5_no_wr", wr_cnt, 0);
    chk_eq("t5_rdy", rdy, 1);
    clear_mon();
    send_t1(t);
    wait_done(1, 100);
    exp_len  = t1_len;
    exp_code = t1_code;
    check_tbl("t5", NSYM, 0);

    // Test 6: beat held through NXTC/ASGN/DONE, out-of-range symbol
    clear_mon();
    send_beat(3, 2, 1'b1, t);
    send_beat(300, 3, 1'b1, t2);
    chk_eq("t6_held_acc", t2, t + 25);
    chk_eq("t6_a_done_cyc", done_cyc, t + 24);
    chk_eq("t6_a_len3", m_len[3], 2);
    chk_eq("t6_a_code3", m_code[3], 0);
    wait_done(2, 100);
    chk_eq("t6_err_cnt", err_cnt, 1);
    chk_eq("t6_err_cyc", err_cyc, t2 + 1);
    chk_eq("t6_b_done_cyc", done_cyc, t2 + 24);
    exp_len  = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_code = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_tbl("t6", 2 * NSYM, 0);

    // First out-of-range symbol mixed into a valid table
    clear_mon();
    send_beat(NSYM, 2, 1'b0, t);
    send_beat(1, 1, 1'b1, t2);
    wait_done(1, 100);
    chk_eq("t7_err_cnt", err_cnt, 1);
    chk_eq("t7_err_cyc", err_cyc, t + 1);
    exp_len  = '{0, 1, 0, 0, 0, 0, 0, 0};
    exp_code = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_tbl("t7", NSYM, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
